iter_alu: RTL and testbench



---
 rtl/iter_alu.sv | 259 +++++++++++++++++++++++++
 tb/tb_iter_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu -- execute stage feeding the register file write port.
//
// Simple ops (FWD/ADD/AND/OR) complete one cycle after accept. MUL runs a
// shift-add loop of MUL_CYCLES iterations; LSHIFT/SRA/ROR move one bit
// position per cycle. Work happens on private copies of the operands taken
// at accept, and RESULT/WRADDR are only updated on completion.
//
// Ports:
//   CLK       clock, all state changes on posedge
//   RESET     synchronous active-high reset, overrides START
//   START     operation request, accepted only while BUSY=0
//   SELECT    000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL,
//             101 LSHIFT, 110 SRA, 111 ROR
//   DATA1     operand A
//   DATA2     operand B / signed shift amount
//   DESTADDR  destination register, presented on WRADDR at completion
//   RESULT    completed result, held until the next completion
//   WRADDR    destination of the completed result
//   WRITE     one-cycle register-file write strobe (same cycle as DONE)
//   DONE      one-cycle completion pulse
//   BUSY      operation in flight
//   ZERO      RESULT == 0 (combinational)
// -----------------------------------------------------------------------------
module iter_alu #(
   parameter int WIDTH      = 8,
   parameter int MUL_CYCLES = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic [2:0]       DESTADDR,
   output logic [WIDTH-1:0] RESULT,
   output logic [2:0]       WRADDR,
   output logic             WRITE,
   output logic             DONE,
   output logic             BUSY,
   output logic             ZERO
);

   // Count register must hold values up to WIDTH (capped shift) and MUL_CYCLES.
   localparam int CW = $clog2(WIDTH + 1);
   // Bits of DATA2 used as the rotate amount (modulo WIDTH).
   localparam int RW = $clog2(WIDTH);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_LSH = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_ROR = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state;
   logic [2:0]       op;          // captured SELECT
   logic [2:0]       dest;        // captured DESTADDR
   logic [WIDTH-1:0] acc;         // working value / product accumulator
   logic [WIDTH-1:0] mcand;       // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier;      // multiplier, shifted right each step
   logic [CW-1:0]    count;       // steps still to perform, including this one
   logic             step_en;     // 0 for ops whose value is final at accept
   logic             shift_left;  // LSHIFT direction

   // Values loaded at accept
   logic [WIDTH-1:0] init_acc;
   logic [CW-1:0]    init_cnt;
   logic             init_step;
   logic             init_left;
   logic [CW-1:0]    shamt;

   // One iteration applied to the working registers
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mcand_step;
   logic [WIDTH-1:0] mplier_step;

   // Limit an unsigned shift magnitude to WIDTH; larger shifts give the same
   // result as WIDTH and this bounds the iteration count.
   function automatic logic [CW-1:0] cap_amount(input logic [WIDTH-1:0] mag);
      logic [CW-1:0] amt;
      if (mag >= WIDTH'(WIDTH)) begin
         amt = CW'(WIDTH);
      end else begin
         amt = CW'(mag);
      end
      return amt;
   endfunction

   // Magnitude of a two's-complement shift amount (-128 maps to 128).
   function automatic logic [WIDTH-1:0] abs_amount(input logic [WIDTH-1:0] amt);
      logic [WIDTH-1:0] mag;
      if (amt[WIDTH-1]) begin
         mag = ~amt + ONE_W;
      end else begin
         mag = amt;
      end
      return mag;
   endfunction

   // Accept-time setup: simple ops are evaluated here and only carried to
   // RESULT later; iterative ops load their step count.
   always_comb begin
      init_acc  = DATA1;
      init_cnt  = CW'(1);
      init_step = 1'b0;
      init_left = 1'b1;
      shamt     = {CW{1'b0}};
      case (SELECT)
         OP_FWD: init_acc = DATA2;
         OP_ADD: init_acc = DATA1 + DATA2;
         OP_AND: init_acc = DATA1 & DATA2;
         OP_OR:  init_acc = DATA1 | DATA2;
         OP_MUL: begin
            init_acc  = ZERO_W;
            init_cnt  = CW'(MUL_CYCLES);
            init_step = 1'b1;
         end
         OP_LSH: begin
            init_left = ~DATA2[WIDTH-1];
            shamt     = cap_amount(abs_amount(DATA2));
         end
         OP_SRA: shamt = cap_amount({{(WIDTH-4){1'b0}}, DATA2[3:0]});
         OP_ROR: shamt = CW'(DATA2[RW-1:0]);
         default: init_acc = DATA1;
      endcase
      // A zero shift passes DATA1 through in a single cycle.
      if (shamt != {CW{1'b0}}) begin
         init_cnt  = shamt;
         init_step = 1'b1;
      end else begin
         init_step = init_step;
      end
   end

   // Single iteration of the captured op on the working registers.
   always_comb begin
      acc_step    = acc;
      mcand_step  = mcand;
      mplier_step = mplier;
      if (step_en) begin
         case (op)
            OP_MUL: begin
               // Low WIDTH bits of a shift-add product are sign-correct.
               if (mplier[0]) begin
                  acc_step = acc + mcand;
               end else begin
                  acc_step = acc;
               end
               mcand_step  = {mcand[WIDTH-2:0], 1'b0};
               mplier_step = {1'b0, mplier[WIDTH-1:1]};
            end
            OP_LSH: begin
               if (shift_left) begin
                  acc_step = {acc[WIDTH-2:0], 1'b0};
               end else begin
                  acc_step = {1'b0, acc[WIDTH-1:1]};
               end
            end
            OP_SRA:  acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROR:  acc_step = {acc[0], acc[WIDTH-1:1]};
            default: acc_step = acc;
         endcase
      end else begin
         acc_step = acc;
      end
   end

   // Control FSM and registered outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         op         <= 3'b000;
         dest       <= 3'b000;
         acc        <= ZERO_W;
         mcand      <= ZERO_W;
         mplier     <= ZERO_W;
         count      <= {CW{1'b0}};
         step_en    <= 1'b0;
         shift_left <= 1'b1;
         RESULT     <= ZERO_W;
         WRADDR     <= 3'b000;
         WRITE      <= 1'b0;
         DONE       <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE  <= 1'b0;
               WRITE <= 1'b0;
               if (START) begin
                  op         <= SELECT;
                  dest       <= DESTADDR;
                  acc        <= init_acc;
                  mcand      <= DATA1;
                  mplier     <= DATA2;
                  count      <= init_cnt;
                  step_en    <= init_step;
                  shift_left <= init_left;
                  BUSY       <= 1'b1;
                  // Single-step ops go straight to the committing state.
                  if (init_cnt == CW'(1)) begin
                     state <= FINISH;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               DONE   <= 1'b0;
               WRITE  <= 1'b0;
               acc    <= acc_step;
               mcand  <= mcand_step;
               mplier <= mplier_step;
               count  <= count - CW'(1);
               // Two left means this step plus the one done in FINISH.
               if (count == CW'(2)) begin
                  state <= FINISH;
               end else begin
                  state <= RUN;
               end
            end
            FINISH: begin
               // Last iteration goes straight to RESULT.
               RESULT <= acc_step;
               WRADDR <= dest;
               acc    <= acc_step;
               count  <= {CW{1'b0}};
               DONE   <= 1'b1;
               WRITE  <= 1'b1;
               BUSY   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               DONE  <= 1'b0;
               WRITE <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign ZERO = (RESULT == ZERO_W);

endmodule

// File: tb/tb_iter_alu.sv
// -----------------------------------------------------------------------------
// tb_iter_alu -- directed bench for iter_alu with a scoreboard of expected
// completions (result, destination, completion cycle).
// -----------------------------------------------------------------------------
module tb_iter_alu;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [2:0] SELECT;
   logic [7:0] DATA1;
   logic [7:0] DATA2;
   logic [2:0] DESTADDR;
   logic [7:0] RESULT;
   logic [2:0] WRADDR;
   logic       WRITE;
   logic       DONE;
   logic       BUSY;
   logic       ZERO;

   iter_alu #(.WIDTH(8), .MUL_CYCLES(8)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
      .DATA1(DATA1), .DATA2(DATA2), .DESTADDR(DESTADDR),
      .RESULT(RESULT), .WRADDR(WRADDR), .WRITE(WRITE), .DONE(DONE),
      .BUSY(BUSY), .ZERO(ZERO)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc = cyc + 1;

   typedef struct {
      logic [7:0] res;
      logic [2:0] addr;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_res = 8'h00;
   logic [7:0] rf[8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: result and latency of one op.
   function automatic void model(input logic [2:0] sel, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output int lat);
      int n;
      logic signed [7:0] s;
      logic [15:0] dbl;
      n = 0;
      lat = 1;
      s = a;
      dbl = {a, a};
      case (sel)
         3'd0: r = b;
         3'd1: r = a + b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: begin r = a * b; lat = 8; end
         3'd5: begin
            if (!b[7]) n = (int'(b) > 8) ? 8 : int'(b);
            else       n = ((256 - int'(b)) > 8) ? 8 : (256 - int'(b));
            r = b[7] ? (a >> n) : (a << n);
         end
         3'd6: begin
            n = (int'(b[3:0]) > 8) ? 8 : int'(b[3:0]);
            r = s >>> n;
         end
         3'd7: begin
            n = int'(b[2:0]);
            dbl = dbl >> n;
            r = dbl[7:0];
         end
         default: r = 8'h00;
      endcase
      if (sel >= 3'd5) lat = (n == 0) ? 1 : n;
   endfunction

   // Output monitor: pops the scoreboard on DONE, otherwise checks that
   // nothing leaks onto the write-back outputs.
   always @(negedge CLK) begin
      if (RESET !== 1'b1) begin
         if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {31'd0, DONE}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result",  {24'd0, RESULT}, {24'd0, e.res});
               chk("wraddr",  {29'd0, WRADDR}, {29'd0, e.addr});
               chk("write",   {31'd0, WRITE}, 32'd1);
               chk("zero",    {31'd0, ZERO}, {31'd0, (e.res == 8'h00)});
               chk("busy_done", {31'd0, BUSY}, 32'd0);
               chk("latency", cyc, e.due);
               last_res = e.res;
            end
         end else begin
            chk("write_idle",  {31'd0, WRITE}, 32'd0);
            chk("result_hold", {24'd0, RESULT}, {24'd0, last_res});
            if (sb.size() > 0) chk("busy_run", {31'd0, BUSY}, 32'd1);
         end
      end
   end

   // Register-file model written by the write-back port.
   always @(posedge CLK) begin
      if (WRITE === 1'b1) rf[WRADDR] <= RESULT;
   end

   // Drive one op; called 1ns after a posedge.
   task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dst, input logic [7:0] exp_r, input int exp_lat);
      exp_t e;
      START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b; DESTADDR = dst;
      @(posedge CLK); #1;
      e.res = exp_r; e.addr = dst; e.due = cyc + exp_lat;
      sb.push_back(e);
      START = 1'b0;
   endtask

   task automatic issue_m(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] dst);
      logic [7:0] r;
      int lat;
      model(sel, a, b, r, lat);
      issue(sel, a, b, dst, r, lat);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < 20) begin
         @(posedge CLK); #1;
         n = n + 1;
      end
      if (DONE !== 1'b1) chk("done_timeout", {31'd0, DONE}, 32'd1);
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; SELECT = 3'd0; DATA1 = 8'd0; DATA2 = 8'd0; DESTADDR = 3'd0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_result", {24'd0, RESULT}, 32'd0);
      chk("rst_wraddr", {29'd0, WRADDR}, 32'd0);
      chk("rst_write",  {31'd0, WRITE}, 32'd0);
      chk("rst_done",   {31'd0, DONE}, 32'd0);
      chk("rst_busy",   {31'd0, BUSY}, 32'd0);
      chk("rst_zero",   {31'd0, ZERO}, 32'd1);
      RESET = 1'b0;
      @(posedge CLK); #1;

      // Directed values
      issue(3'b001, 8'd100, 8'd50, 3'd3, 8'h96, 1);       wait_done();
      issue(3'b100, 8'd7, 8'hFD, 3'd4, 8'hEB, 8);         wait_done();
      issue(3'b100, 8'd0, 8'hFD, 3'd4, 8'h00, 8);         wait_done();
      issue(3'b101, 8'h81, 8'd3, 3'd1, 8'h08, 3);         wait_done();
      issue(3'b101, 8'h81, 8'hFE, 3'd1, 8'h20, 2);        wait_done();
      issue(3'b110, 8'h90, 8'd2, 3'd2, 8'hE4, 2);         wait_done();
      issue(3'b111, 8'h81, 8'd1, 3'd6, 8'hC0, 1);         wait_done();
      issue(3'b110, 8'h80, 8'd12, 3'd7, 8'hFF, 8);        wait_done();
      issue(3'b101, 8'h5A, 8'h80, 3'd5, 8'h00, 8);        wait_done();
      issue(3'b101, 8'h5A, 8'd0, 3'd5, 8'h5A, 1);         wait_done();
      issue(3'b111, 8'h5A, 8'd8, 3'd5, 8'h5A, 1);         wait_done();

      // Model-driven mix
      issue_m(3'b000, 8'h3C, 8'hA5, 3'd0); wait_done();
      issue_m(3'b010, 8'h3C, 8'hA5, 3'd1); wait_done();
      issue_m(3'b011, 8'h3C, 8'hA5, 3'd2); wait_done();
      issue_m(3'b001, 8'hF0, 8'h20, 3'd3); wait_done();
      issue_m(3'b100, 8'hF6, 8'hF6, 3'd4); wait_done();
      issue_m(3'b101, 8'h01, 8'd100, 3'd5); wait_done();
      issue_m(3'b111, 8'hB3, 8'd13, 3'd6); wait_done();
      issue_m(3'b110, 8'h4F, 8'd5, 3'd7); wait_done();
      for (int i = 0; i < 6; i++) begin
         issue_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
         wait_done();
      end

      // START while busy is ignored; operand changes after accept are too.
      issue(3'b100, 8'd7, 8'hFD, 3'd5, 8'hEB, 8);
      @(posedge CLK); #1;
      START = 1'b1; SELECT = 3'b001; DATA1 = 8'd1; DATA2 = 8'd1; DESTADDR = 3'd0;
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done();
      // START during the DONE cycle: accepted at the next edge.
      issue(3'b001, 8'd20, 8'd22, 3'd6, 8'd42, 1);
      wait_done();

      // Reset aborts an in-flight multiply.
      issue(3'b100, 8'd5, 8'd5, 3'd1, 8'd25, 8);
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      sb.delete();
      last_res = 8'h00;
      @(posedge CLK); #1;
      RESET = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      chk("abort_result", {24'd0, RESULT}, 32'd0);
      chk("abort_busy",   {31'd0, BUSY}, 32'd0);
      chk("abort_zero",   {31'd0, ZERO}, 32'd1);

      // Write-back into the register file, read back two cycles later.
      issue(3'b001, 8'd1, 8'd1, 3'd2, 8'd2, 1);
      wait_done();
      repeat (2) @(posedge CLK);
      #1;
      chk("rf_readback", {24'd0, rf[2]}, 32'd2);

      repeat (3) @(posedge CLK);
      #1;
      if (sb.size() != 0) chk("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
